// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low column drives, debounces one
// pressed row at a time and shifts accepted hex codes into a 16-bit history.
module keypad_scanner #(
    parameter int unsigned SCAN_PERIOD    = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    input  logic        clr,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] dataout
);

    localparam int unsigned TICK_W = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          cols_q, cols_d;
    logic [1:0]          row_q, row_d;
    logic [3:0]          sync1_q, sync2_q;
    logic                key_valid_q, key_valid_d;
    logic [3:0]          key_code_q, key_code_d;
    logic [15:0]         dataout_q, dataout_d;

    logic                tick_c;
    logic                key_c;
    logic [1:0]          row_c;
    logic [1:0]          col_c;
    logic                accept_c;
    logic [3:0]          code_c;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Free-running scan tick, independent of FSM state
    always_comb begin
        tick_c     = (tick_cnt_q == TICK_W'(SCAN_PERIOD - 1));
        tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
    end

    // Exactly one low row is a key; anything else is treated as no key
    always_comb begin
        key_c = 1'b1;
        row_c = 2'd0;
        case (sync2_q)
            4'b1110: row_c = 2'd0;
            4'b1101: row_c = 2'd1;
            4'b1011: row_c = 2'd2;
            4'b0111: row_c = 2'd3;
            default: key_c = 1'b0;
        endcase
    end

    always_comb begin
        case (cols_q)
            4'b1101: col_c = 2'd1;
            4'b1011: col_c = 2'd2;
            4'b0111: col_c = 2'd3;
            default: col_c = 2'd0;
        endcase
    end

    assign code_c = key_map(row_q, col_c);

    always_comb begin
        state_d  = state_q;
        cols_d   = cols_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        if (tick_c) begin
            case (state_q)
                SCAN: begin
                    if (key_c) begin
                        row_d   = row_c;
                        cnt_d   = CNT_W'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        cols_d = {cols_q[2:0], cols_q[3]};
                    end
                end
                DEBOUNCE: begin
                    if (key_c && (row_c == row_q)) begin
                        if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                            accept_c = 1'b1;
                            cnt_d    = '0;
                            state_d  = HELD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d   = '0;
                        cols_d  = {cols_q[2:0], cols_q[3]};
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (!key_c) begin
                        cnt_d   = CNT_W'(1);
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    // Column stays put on exit so the same column is re-checked first
                    if (!key_c) begin
                        if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                            cnt_d   = '0;
                            state_d = SCAN;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end
    end

    // Output registers; clr only touches the history
    always_comb begin
        key_valid_d = accept_c;
        key_code_d  = accept_c ? code_c : key_code_q;
        dataout_d   = dataout_q;
        if (clr) begin
            dataout_d = accept_c ? {12'h000, code_c} : 16'h0000;
        end else if (accept_c) begin
            dataout_d = {dataout_q[11:0], code_c};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            tick_cnt_q  <= '0;
            cnt_q       <= '0;
            cols_q      <= 4'b1110;
            row_q       <= 2'd0;
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            dataout_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            cnt_q       <= cnt_d;
            cols_q      <= cols_d;
            row_q       <= row_d;
            sync1_q     <= rows;
            sync2_q     <= sync1_q;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            dataout_q   <= dataout_d;
        end
    end

    assign cols      = cols_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign dataout   = dataout_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a switch-matrix model drives rows from
// cols, presses push expected (code, history) entries, a monitor pops on key_valid.
module tb_keypad_scanner;

    localparam int unsigned SP = 4;
    localparam int unsigned DT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        clr;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] dataout;

    logic [3:0]  pressed [4];

    typedef struct {
        logic [3:0]  code;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_data = 16'h0000;

    keypad_scanner #(.SCAN_PERIOD(SP), .DEBOUNCE_TICKS(DT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rows      (rows),
        .cols      (cols),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .dataout   (dataout)
    );

    always #5 clk = ~clk;

    // Switch matrix: a closed switch pulls its row low while its column is driven
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r][c] && (cols[c] == 1'b0)) rows[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: key_code %0h dataout %0h at %0t", key_code, dataout, $time);
            end else begin
                e = exp_q.pop_front();
                check("pulse_code", 32'(key_code), 32'(e.code));
                check("pulse_data", 32'(dataout), 32'(e.data));
            end
        end
    end

    task automatic expect_key(input logic [3:0] code, input bit with_clr);
        exp_t e;
        model_data = with_clr ? {12'h000, code} : {model_data[11:0], code};
        e.code = code;
        e.data = model_data;
        exp_q.push_back(e);
    endtask

    // Wait for a fresh entry of the scan into the given column
    task automatic wait_col(input logic [3:0] pat);
        int n = 0;
        while (cols === pat && n < 200) begin @(negedge clk); n++; end
        while (cols !== pat && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_col: cols %b never reached %b", cols, pat);
        end
    endtask

    task automatic wait_pulse(output int lat, input bit with_clr);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            clr = with_clr && (lat == 11);
        end while (key_valid !== 1'b1 && lat < 60);
        clr = 1'b0;
        if (key_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL pulse_timeout: no key_valid after %0d cycles", lat);
        end
    endtask

    task automatic press(input int r, input int c, input logic [3:0] code,
                         input bit with_clr, input bit repress);
        logic [3:0] pat;
        int lat;
        pat = ~(4'b0001 << c);
        wait_col(pat);
        pressed[r][c] = 1'b1;
        expect_key(code, with_clr);
        wait_pulse(lat, with_clr);
        check("latency", 32'(lat), 32'd12);
        repeat (20) @(negedge clk);
        check("cols_frozen", 32'(cols), 32'(pat));
        if (repress) begin
            pressed[r][c] = 1'b0;
            repeat (6) @(negedge clk);
            pressed[r][c] = 1'b1;
            repeat (20) @(negedge clk);
            check("cols_frozen_repress", 32'(cols), 32'(pat));
        end
        pressed[r][c] = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1;
        clr = 1'b0;
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_cols", 32'(cols), 32'hE);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_data", 32'(dataout), 32'h0);

        // Idle rotation, first tick on the fourth edge after reset release
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 3)  check("idle_cols_k3", 32'(cols), 32'hE);
            if (k == 4)  check("idle_cols_k4", 32'(cols), 32'hD);
            if (k == 8)  check("idle_cols_k8", 32'(cols), 32'hB);
            if (k == 12) check("idle_cols_k12", 32'(cols), 32'h7);
            if (k == 16) check("idle_cols_k16", 32'(cols), 32'hE);
        end

        // Key 5 held, with a brief release that must not retrigger
        press(1, 1, 4'h5, 1'b0, 1'b1);
        check("key5_data", 32'(dataout), 32'h0005);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_data = 16'h0000;
        check("clr_data", 32'(dataout), 32'h0);
        check("clr_keeps_code", 32'(key_code), 32'h5);

        press(0, 0, 4'h1, 1'b0, 1'b0);
        press(0, 3, 4'hA, 1'b0, 1'b0);
        press(3, 1, 4'h0, 1'b0, 1'b0);
        press(3, 2, 4'hF, 1'b0, 1'b0);
        check("seq_1A0F", 32'(dataout), 32'h1A0F);
        press(2, 0, 4'h7, 1'b0, 1'b0);
        check("seq_A0F7", 32'(dataout), 32'hA0F7);

        press(0, 0, 4'h1, 1'b0, 1'b0);
        press(0, 1, 4'h2, 1'b0, 1'b0);
        press(0, 2, 4'h3, 1'b0, 1'b0);
        press(1, 0, 4'h4, 1'b0, 1'b0);
        check("seq_1234", 32'(dataout), 32'h1234);
        press(2, 2, 4'h9, 1'b1, 1'b0);
        check("clr_accept_data", 32'(dataout), 32'h0009);
        check("clr_accept_code", 32'(key_code), 32'h9);

        // Bounce: low one tick, high one tick, then stable low
        wait_col(4'b1101);
        pressed[1][1] = 1'b1;
        expect_key(4'h5, 1'b0);
        repeat (4) @(negedge clk);
        pressed[1][1] = 1'b0;
        repeat (4) @(negedge clk);
        pressed[1][1] = 1'b1;
        wait_pulse(lat, 1'b0);
        check("bounce_latency", 32'(lat + 8), 32'd32);
        repeat (10) @(negedge clk);
        pressed[1][1] = 1'b0;
        repeat (30) @(negedge clk);
        check("bounce_data", 32'(dataout), 32'h0095);

        // Two rows low in one column: never a key, scan keeps moving
        pressed[0][3] = 1'b1;
        pressed[2][3] = 1'b1;
        wait_col(4'b0111);
        repeat (4) @(negedge clk);
        check("multi_row_rotate", 32'(cols), 32'hE);
        repeat (40) @(negedge clk);
        pressed[0][3] = 1'b0;
        pressed[2][3] = 1'b0;
        repeat (20) @(negedge clk);

        // Reset in the middle of debounce
        wait_col(4'b1101);
        pressed[2][1] = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        pressed[2][1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_data = 16'h0000;
        check("rst_debounce_cols", 32'(cols), 32'hE);
        check("rst_debounce_data", 32'(dataout), 32'h0);
        repeat (40) @(negedge clk);

        // Reset while a key is held
        wait_col(4'b1011);
        pressed[0][2] = 1'b1;
        expect_key(4'h3, 1'b0);
        wait_pulse(lat, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        pressed[0][2] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_data = 16'h0000;
        check("rst_held_cols", 32'(cols), 32'hE);
        check("rst_held_code", 32'(key_code), 32'h0);
        check("rst_held_data", 32'(dataout), 32'h0);
        repeat (40) @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
